// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
// Parallel-in / serial-out transmitter. The block takes a WIDTH-bit word over a
// valid/ready handshake and sends it out on Q, one bit per Clk. 'frame' is high
// while a frame bit is on Q. 'done' pulses for one cycle after the last bit.
//
// Parameters
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: D[WIDTH-1] is sent first; 0: D[0] is sent first
//
// Build option
//   PISO_PARITY_EN  When defined, an even-parity bit (XOR of all data bits)
//                   is appended after the data bits and frame stays high for
//                   it. When undefined, no parity logic is built.
//
// Ports
//   Clk         in   clock, all state changes on posedge
//   rst         in   asynchronous reset, active-high
//   D           in   parallel word to transmit (sampled only on accept)
//   load_valid  in   producer presents a word on D
//   load_ready  out  block can accept a word this cycle
//   Q           out  serial data, registered (0 when idle)
//   nQ          out  ~Q, combinational
//   frame       out  high while a frame bit is on Q
//   done        out  one-cycle pulse after the last frame bit
// -----------------------------------------------------------------------------
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             Q,
  output logic             nQ,
  output logic             frame,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [NBITS-1:0] shreg_q;
  logic [NBITS-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             q_q;
  logic             frame_q;
  logic             done_q;
  logic             ready_q;

  // Word rearranged into transmission order: bit [WIDTH-1] goes out first.
  logic [WIDTH-1:0] data_ord;
  // Whole frame in transmission order: bit [NBITS-1] goes out first.
  logic [NBITS-1:0] frame_bits;

  always_comb begin
    data_ord = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        data_ord[i] = D[i];
      end else begin
        data_ord[i] = D[WIDTH-1-i];
      end
    end
  end

`ifdef PISO_PARITY_EN
  // Even parity: the appended bit makes the total count of ones even.
  assign frame_bits = {data_ord, ^D};
`else
  assign frame_bits = data_ord;
`endif

  assign shreg_d = {shreg_q[NBITS-2:0], 1'b0};
  assign cnt_d   = cnt_q - CW'(1);

  // Single FSM process. All outputs are registered.
  // On accept, the first bit goes straight to Q. The remaining bits are held
  // left-aligned in shreg_q, and cnt_q counts down how many bits are still
  // to be sent. When cnt_q is zero in SHIFT, the last bit has already been on
  // Q for a full cycle, so this edge closes the frame.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (load_valid && ready_q) begin
            state_q <= S_SHIFT;
            q_q     <= frame_bits[NBITS-1];
            shreg_q <= {frame_bits[NBITS-2:0], 1'b0};
            cnt_q   <= CW'(NBITS - 1);
            frame_q <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            q_q     <= shreg_q[NBITS-1];
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
          end else begin
            state_q <= S_IDLE;
            q_q     <= 1'b0;
            shreg_q <= '0;
            frame_q <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          q_q     <= 1'b0;
          frame_q <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Q          = q_q;
  assign nQ         = ~q_q;
  assign frame      = frame_q;
  assign done       = done_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_tx
// Two transmitters, one MSB-first and one LSB-first, are driven by the same
// stimulus. A frame-position model predicts every output on every cycle.
// Hand-computed bit sequences pin that model.
// -----------------------------------------------------------------------------
module tb_piso_shift_tx;

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] D = '0;
  logic       load_valid = 1'b0;

  logic ready_m, q_m, nq_m, frame_m, done_m;
  logic ready_l, q_l, nq_l, frame_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .Clk(clk), .rst(rst), .D(D), .load_valid(load_valid),
    .load_ready(ready_m), .Q(q_m), .nQ(nq_m), .frame(frame_m), .done(done_m)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .Clk(clk), .rst(rst), .D(D), .load_valid(load_valid),
    .load_ready(ready_l), .Q(q_l), .nQ(nq_l), .frame(frame_l), .done(done_l)
  );

  always #5 clk = ~clk;

  // Model: pos = -1 when idle, 0..NB-1 while bit pos is on Q, NB in the done cycle.
  int         pos = -1;
  logic [7:0] word = '0;

  function automatic logic tx_bit(input logic [7:0] w, input int i, input bit msb);
    if (i >= 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = -1;
    end else if ((pos < 0 || pos == NB) && load_valid) begin
      word = D;
      pos  = 0;
    end else if (pos >= 0 && pos < NB) begin
      pos = pos + 1;
    end else begin
      pos = -1;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      automatic bit   busy = (pos >= 0 && pos < NB);
      automatic logic em   = busy ? tx_bit(word, pos, 1'b1) : 1'b0;
      automatic logic el   = busy ? tx_bit(word, pos, 1'b0) : 1'b0;
      chk("model_Q_msb", q_m, em);
      chk("model_nQ_msb", nq_m, ~em);
      chk("model_frame_msb", frame_m, busy);
      chk("model_done_msb", done_m, pos == NB);
      chk("model_ready_msb", ready_m, !busy);
      chk("model_Q_lsb", q_l, el);
      chk("model_nQ_lsb", nq_l, ~el);
      chk("model_frame_lsb", frame_l, busy);
      chk("model_done_lsb", done_l, pos == NB);
      chk("model_ready_lsb", ready_l, !busy);
    end
  end

  task automatic chk_reset_vals();
    chk("rst_Q_msb", q_m, 1'b0);
    chk("rst_nQ_msb", nq_m, 1'b1);
    chk("rst_frame_msb", frame_m, 1'b0);
    chk("rst_done_msb", done_m, 1'b0);
    chk("rst_ready_msb", ready_m, 1'b1);
    chk("rst_Q_lsb", q_l, 1'b0);
    chk("rst_ready_lsb", ready_l, 1'b1);
  endtask

  // seq_m / seq_l: expected serial sequence, first bit in [7].
  task automatic send_word(input logic [7:0] d, input logic [7:0] seq_m,
                           input logic [7:0] seq_l, input logic par);
    @(negedge clk);
    D = d;
    load_valid = 1'b1;
    chk("ready_before_msb", ready_m, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    D = ~d;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("lit_Q_msb", q_m, seq_m[7-i]);
      chk("lit_Q_lsb", q_l, seq_l[7-i]);
      chk("lit_nQ_msb", nq_m, ~seq_m[7-i]);
      chk("lit_frame_msb", frame_m, 1'b1);
      chk("lit_ready_busy", ready_m, 1'b0);
    end
`ifdef PISO_PARITY_EN
    @(negedge clk);
    chk("lit_par_msb", q_m, par);
    chk("lit_par_lsb", q_l, par);
    chk("lit_par_frame", frame_m, 1'b1);
`else
    if (par !== 1'b0 && par !== 1'b1) $display("note: parity value unknown");
`endif
    @(negedge clk);
    chk("lit_done_msb", done_m, 1'b1);
    chk("lit_done_lsb", done_l, 1'b1);
    chk("lit_end_frame", frame_m, 1'b0);
    chk("lit_end_Q", q_m, 1'b0);
    chk("lit_end_ready", ready_m, 1'b1);
    @(negedge clk);
    chk("lit_done_clear", done_m, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset_vals();
    started = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done", done_m, 1'b0);
    chk("idle_frame", frame_m, 1'b0);

    // A5 is its own bit reversal; 1E is not (LSB-first sequence is 78).
    send_word(8'hA5, 8'hA5, 8'hA5, 1'b0);
    send_word(8'h1E, 8'h1E, 8'h78, 1'b0);
    send_word(8'h07, 8'h07, 8'hE0, 1'b1);
    send_word(8'h03, 8'h03, 8'hC0, 1'b0);

    // Back-to-back with load_valid held high: FF, then 00.
    @(negedge clk);
    D = 8'hFF;
    load_valid = 1'b1;
    @(negedge clk);
    D = 8'h00;
    repeat (NB - 1) @(negedge clk);
    chk("b2b_last_frame", frame_m, 1'b1);
    chk("b2b_last_Q", q_m, 1'b1);
    @(negedge clk);
    chk("b2b_done1", done_m, 1'b1);
    chk("b2b_gap_frame", frame_m, 1'b0);
    chk("b2b_gap_Q", q_m, 1'b0);
    @(negedge clk);
    chk("b2b_second_frame", frame_m, 1'b1);
    chk("b2b_second_Q", q_m, 1'b0);
    chk("b2b_second_ready", ready_m, 1'b0);
    chk("b2b_done_cleared", done_m, 1'b0);
    load_valid = 1'b0;
    repeat (NB - 1) @(negedge clk);
    chk("b2b_second_last", frame_m, 1'b1);
    @(negedge clk);
    chk("b2b_done2", done_m, 1'b1);
    @(negedge clk);
    chk("b2b_idle_ready", ready_m, 1'b1);

    // Reset asserted during a frame, held across edge k+3.
    @(negedge clk);
    D = 8'h1E;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NB + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_m, 1'b0);
      chk("abort_no_frame", frame_m, 1'b0);
    end
    send_word(8'h5C, 8'h5C, 8'h3A, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
